// File: rtl/sha256_iter_core.sv
// sha256_iter_core
//   Iterative SHA-256 compression core. Applies ROUNDS_PER_CYCLE chained
//   rounds per clock to one 512-bit block and a 256-bit chaining state.
//   Handshakes on both sides with valid/ready.
//
//   Optional feature macro: SHA256_FEEDFORWARD_EN
//     defined   : tx_hash = chaining state + final working state (FIPS output)
//     undefined : tx_hash = raw working state a..h after round 63
//
//   Ports
//     clk        rising-edge clock
//     reset      asynchronous active-high reset
//     in_valid   block and chaining state presented
//     in_ready   core accepts a block this cycle
//     rx_state   chaining state, word i at [32i+31:32i], word 0 = a
//     rx_input   message block, word i = W[i] at [32i+31:32i]
//     out_valid  tx_hash valid
//     out_ready  consumer takes tx_hash this cycle
//     tx_hash    result, same packing as rx_state
//     busy       high while rounds or the final write are in progress
module sha256_iter_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] rx_state,
  input  logic [511:0] rx_input,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] tx_hash,
  output logic         busy
);

  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
      ROUNDS_PER_CYCLE != 4 && ROUNDS_PER_CYCLE != 8) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_t;

  state_t      state, state_nxt;
  logic [5:0]  rc;
  logic        accept;
  logic        last_run;
  logic [31:0] ws [8];       // working a..h
  logic [31:0] w [16];       // message schedule window, w[0] = W[t]
  logic [31:0] ws_nxt [8];
  logic [31:0] w_nxt [16];
`ifdef SHA256_FEEDFORWARD_EN
  logic [31:0] iv [8];
`endif

  // rc wraps to 0 on the same edge that leaves RUN
  assign last_run = (rc == 6'(64 - ROUNDS_PER_CYCLE));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_run) state_nxt = FINAL;
      end
      FINAL: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // Taking the result frees the core, so a new block may enter now
        in_ready  = out_ready;
        if (out_ready) state_nxt = in_valid ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Round datapath: ROUNDS_PER_CYCLE rounds chained combinationally, the
  // window advancing one word per round so round j sees original head j.
  always_comb begin
    logic [31:0] t1, t2, wn;
    ws_nxt = ws;
    w_nxt  = w;
    t1 = '0;
    t2 = '0;
    wn = '0;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      t1 = ws_nxt[7] + bsig1(ws_nxt[4]) +
           ((ws_nxt[4] & ws_nxt[5]) ^ (~ws_nxt[4] & ws_nxt[6])) +
           K[rc + 6'(j)] + w_nxt[0];
      t2 = bsig0(ws_nxt[0]) +
           ((ws_nxt[0] & ws_nxt[1]) ^ (ws_nxt[0] & ws_nxt[2]) ^ (ws_nxt[1] & ws_nxt[2]));
      ws_nxt[7] = ws_nxt[6];
      ws_nxt[6] = ws_nxt[5];
      ws_nxt[5] = ws_nxt[4];
      ws_nxt[4] = ws_nxt[3] + t1;
      ws_nxt[3] = ws_nxt[2];
      ws_nxt[2] = ws_nxt[1];
      ws_nxt[1] = ws_nxt[0];
      ws_nxt[0] = t1 + t2;
      wn = ssig1(w_nxt[14]) + w_nxt[9] + ssig0(w_nxt[1]) + w_nxt[0];
      for (int i = 0; i < 15; i++) w_nxt[i] = w_nxt[i + 1];
      w_nxt[15] = wn;
    end
  end

  // Control and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rc      <= '0;
      tx_hash <= '0;
    end else begin
      state <= state_nxt;
      if (accept) rc <= '0;
      else if (state == RUN) rc <= rc + 6'(ROUNDS_PER_CYCLE);
      if (state == FINAL) begin
        for (int i = 0; i < 8; i++) begin
`ifdef SHA256_FEEDFORWARD_EN
          tx_hash[32*i +: 32] <= iv[i] + ws[i];
`else
          tx_hash[32*i +: 32] <= ws[i];
`endif
        end
      end
    end
  end

  // Working state and schedule window
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < 8; i++) begin
        ws[i] <= rx_state[32*i +: 32];
`ifdef SHA256_FEEDFORWARD_EN
        iv[i] <= rx_state[32*i +: 32];
`endif
      end
      for (int i = 0; i < 16; i++) w[i] <= rx_input[32*i +: 32];
    end else if (state == RUN) begin
      ws <= ws_nxt;
      w  <= w_nxt;
    end
  end

endmodule

// File: tb/tb_sha256_iter_core.sv
module tb_sha256_iter_core;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         out_ready;
  logic [255:0] rx_state;
  logic [511:0] rx_input;

  logic         in_ready, out_valid, busy;
  logic [255:0] tx_hash;
  logic         in_ready_2, out_valid_2, busy_2;
  logic [255:0] tx_hash_2;
  logic         in_ready_4, out_valid_4, busy_4;
  logic [255:0] tx_hash_4;
  logic         in_ready_8, out_valid_8, busy_8;
  logic [255:0] tx_hash_8;

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] iv_msf, abc_msf, empty_msf;
  logic [255:0] iv_p, exp_abc, exp_empty;
  logic [511:0] blk_abc, blk_empty;

  always #5 clk = ~clk;

  sha256_iter_core #(.ROUNDS_PER_CYCLE(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rx_state(rx_state), .rx_input(rx_input), .out_valid(out_valid),
    .out_ready(out_ready), .tx_hash(tx_hash), .busy(busy));

  sha256_iter_core #(.ROUNDS_PER_CYCLE(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_2),
    .rx_state(rx_state), .rx_input(rx_input), .out_valid(out_valid_2),
    .out_ready(out_ready), .tx_hash(tx_hash_2), .busy(busy_2));

  sha256_iter_core #(.ROUNDS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_4),
    .rx_state(rx_state), .rx_input(rx_input), .out_valid(out_valid_4),
    .out_ready(out_ready), .tx_hash(tx_hash_4), .busy(busy_4));

  sha256_iter_core #(.ROUNDS_PER_CYCLE(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_8),
    .rx_state(rx_state), .rx_input(rx_input), .out_valid(out_valid_8),
    .out_ready(out_ready), .tx_hash(tx_hash_8), .busy(busy_8));

  // Constants are written word 0 first (MSBs); the port packs word 0 at LSBs.
  function automatic logic [255:0] rev8(input logic [255:0] msf);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = msf[255-32*i -: 32];
    return r;
  endfunction

  function automatic logic [255:0] expect_hash(input logic [255:0] dig_msf,
                                               input logic [255:0] ivm);
    logic [255:0] r;
    logic [31:0]  wd;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      wd = dig_msf[255-32*i -: 32];
`ifndef SHA256_FEEDFORWARD_EN
      wd = wd - ivm[255-32*i -: 32];
`endif
      r[32*i +: 32] = wd;
    end
    return r;
  endfunction

  task automatic issue(input logic [511:0] blk);
    rx_state = iv_p;
    rx_input = blk;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (tx_hash !== 256'h0) begin n_fail++; $display("FAIL reset_tx_hash: got %h want 0", tx_hash); end
    #2 reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_empty_all_rpc();
    int l1, l2, l4, l8;
    l1 = 0; l2 = 0; l4 = 0; l8 = 0;
    issue(blk_empty);
    n_checks++;
    if ({busy, busy_2, busy_4, busy_8} !== 4'hf) begin
      n_fail++; $display("FAIL empty_busy_rise: got %b want 1111", {busy, busy_2, busy_4, busy_8});
    end
    n_checks++;
    if ({in_ready, in_ready_2, in_ready_4, in_ready_8} !== 4'h0) begin
      n_fail++; $display("FAIL empty_in_ready_run: got %b want 0000", {in_ready, in_ready_2, in_ready_4, in_ready_8});
    end
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1 && l1 == 0) l1 = c;
      if (out_valid_2 === 1'b1 && l2 == 0) l2 = c;
      if (out_valid_4 === 1'b1 && l4 == 0) l4 = c;
      if (out_valid_8 === 1'b1 && l8 == 0) l8 = c;
      if (l1 != 0 && l2 != 0 && l4 != 0 && l8 != 0) break;
    end
    n_checks++;
    if (l1 != 65) begin n_fail++; $display("FAIL empty_lat_rpc1: got %0d want 65", l1); end
    n_checks++;
    if (l2 != 33) begin n_fail++; $display("FAIL empty_lat_rpc2: got %0d want 33", l2); end
    n_checks++;
    if (l4 != 17) begin n_fail++; $display("FAIL empty_lat_rpc4: got %0d want 17", l4); end
    n_checks++;
    if (l8 != 9) begin n_fail++; $display("FAIL empty_lat_rpc8: got %0d want 9", l8); end
    n_checks++;
    if (tx_hash !== exp_empty) begin n_fail++; $display("FAIL empty_hash_rpc1: got %h want %h", tx_hash, exp_empty); end
    n_checks++;
    if (tx_hash_2 !== exp_empty) begin n_fail++; $display("FAIL empty_hash_rpc2: got %h want %h", tx_hash_2, exp_empty); end
    n_checks++;
    if (tx_hash_4 !== exp_empty) begin n_fail++; $display("FAIL empty_hash_rpc4: got %h want %h", tx_hash_4, exp_empty); end
    n_checks++;
    if (tx_hash_8 !== exp_empty) begin n_fail++; $display("FAIL empty_hash_rpc8: got %h want %h", tx_hash_8, exp_empty); end
    release_out();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL empty_release: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_abc();
    int lat;
    issue(blk_abc);
    wait_valid(lat);
    n_checks++;
    if (lat != 65) begin n_fail++; $display("FAIL abc_latency: got %0d want 65", lat); end
    n_checks++;
    if (tx_hash !== exp_abc) begin n_fail++; $display("FAIL abc_hash: got %h want %h", tx_hash, exp_abc); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abc_busy_done: got %b want 0", busy); end
    release_out();
  endtask

  task automatic test_back_to_back();
    int lat;
    int bad;
    issue(blk_abc);
    wait_valid(lat);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || tx_hash !== exp_abc) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL backpressure_hold: %0d bad cycles, last out_valid=%b in_ready=%b hash=%h want 1 0 %h",
                         bad, out_valid, in_ready, tx_hash, exp_abc);
    end
    rx_state  = iv_p;
    rx_input  = blk_empty;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept: got busy=%b out_valid=%b want 1 0", busy, out_valid);
    end
    wait_valid(lat);
    n_checks++;
    if (lat != 65) begin n_fail++; $display("FAIL b2b_latency: got %0d want 65", lat); end
    n_checks++;
    if (tx_hash !== exp_empty) begin n_fail++; $display("FAIL b2b_hash: got %h want %h", tx_hash, exp_empty); end
    release_out();
  endtask

  task automatic test_ignored_input();
    int lat;
    int bad;
    bad = 0;
    lat = 0;
    issue(blk_abc);
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      lat = c;
      if (out_valid === 1'b1) break;
      if (in_ready !== 1'b0) bad++;
      in_valid = ~in_valid;
      for (int i = 0; i < 16; i++) rx_input[32*i +: 32] = $urandom;
      for (int i = 0; i < 8; i++) rx_state[32*i +: 32] = $urandom;
    end
    in_valid = 1'b0;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL ignored_in_ready: %0d cycles with in_ready=1, want 0", bad); end
    n_checks++;
    if (lat != 65) begin n_fail++; $display("FAIL ignored_latency: got %0d want 65", lat); end
    n_checks++;
    if (tx_hash !== exp_abc) begin n_fail++; $display("FAIL ignored_hash: got %h want %h", tx_hash, exp_abc); end
    release_out();
  endtask

  task automatic test_reset_mid_op();
    int lat;
    issue(blk_abc);
    repeat (32) @(posedge clk);
    #2;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || tx_hash !== 256'h0) begin
      n_fail++; $display("FAIL midrst_clear: got out_valid=%b busy=%b hash=%h want 0 0 0", out_valid, busy, tx_hash);
    end
    #1 reset = 1'b0;
    @(posedge clk); #1;
    issue(blk_abc);
    wait_valid(lat);
    n_checks++;
    if (lat != 65) begin n_fail++; $display("FAIL midrst_latency: got %0d want 65", lat); end
    n_checks++;
    if (tx_hash !== exp_abc) begin n_fail++; $display("FAIL midrst_hash: got %h want %h", tx_hash, exp_abc); end
    release_out();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rx_state  = '0;
    rx_input  = '0;

    iv_msf    = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    abc_msf   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    empty_msf = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    iv_p      = rev8(iv_msf);
    exp_abc   = expect_hash(abc_msf, iv_msf);
    exp_empty = expect_hash(empty_msf, iv_msf);

    blk_abc            = '0;
    blk_abc[31:0]      = 32'h61626380;
    blk_abc[511:480]   = 32'h00000018;
    blk_empty          = '0;
    blk_empty[31:0]    = 32'h80000000;

    test_reset();
    test_empty_all_rpc();
    test_abc();
    test_back_to_back();
    test_ignored_input();
    test_reset_mid_op();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_iter_core.md
# sha256_iter_core

Iterative, handshaked SHA-256 compression core that runs ROUNDS_PER_CYCLE rounds per clock over one 512-bit block and a 256-bit chaining state. It is the parametrised successor to the fixed-loop transform. It adds valid/ready flow control, reset, and a compile-time feed-forward option. It sits between the work dispatcher and the nonce/compare logic, either standalone or chained for double SHA-256.

## Interface
- ROUNDS_PER_CYCLE, default 1: rounds computed per clock. Legal values are 1, 2, 4 and 8; any other value is an elaboration error.
- clk  input  1  rising-edge clock for all state
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  block and state presented
- in_ready  output  1  core can accept a block this cycle
- rx_state  input  256  chaining state; word i at [32i+31:32i], word 0 = a (H0)
- rx_input  input  512  message block; word i = W[i] at [32i+31:32i]
- out_valid  output  1  tx_hash valid
- out_ready  input  1  consumer takes tx_hash this cycle
- tx_hash  output  256  result, same word packing as rx_state
- busy  output  1  high in RUN or FINAL

## Operation
- The FSM has four states: IDLE, RUN, FINAL and DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid: latch rx_state into working a..h and into a saved-IV register, latch rx_input into a 16-word W window, clear round counter rc (6-bit), go to RUN.
- **RUN**
  - Each cycle applies ROUNDS_PER_CYCLE chained standard SHA-256 rounds, using K[rc+j] and W-window head j.
  - The window shifts by ROUNDS_PER_CYCLE words. Each new word is σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], computed sequentially within the cycle.
  - rc advances by ROUNDS_PER_CYCLE. After the cycle that ends with rc+ROUNDS_PER_CYCLE = 64, go to FINAL; rc wraps to 0.
- **FINAL**
  - Register tx_hash: saved-IV + working state word-wise mod 2^32 (see Configuration).
  - Set out_valid, go to DONE.
- **DONE**
  - Hold tx_hash and out_valid until out_ready.
  - On out_ready, clear out_valid; in_ready = out_ready in this state.
  - If out_ready and in_valid both high: load the new block (as in IDLE) and go to RUN. This gives back-to-back issue with no IDLE bubble.
  - If out_ready without in_valid: go to IDLE.
- **Flow-control rules**
  - in_valid in RUN or FINAL is ignored, since in_ready = 0. The upstream source holds the block.
  - out_ready outside DONE has no effect.
- **Arithmetic**: all additions are 32-bit modulo 2^32; carries are discarded.

## Timing
- All outputs reset to 0 and the FSM resets to IDLE. After reset, in_ready is 1 because the state is IDLE.
- Accept edge = edge 0. RUN occupies edges 1..N, N = 64/ROUNDS_PER_CYCLE. FINAL is edge N+1, after which out_valid = 1.
- Latency from accept to out_valid is N+1 clocks: 65 / 33 / 17 / 9.
- Sustained throughput with out_ready held high is one block per N+2 clocks.
- in_ready, out_valid and busy are functions of registered state only; in_ready in DONE additionally depends on out_ready.
- tx_hash changes only at the FINAL edge and is stable throughout DONE.
- Reset asserted mid-RUN or mid-DONE: immediate return to IDLE, out_valid = 0, tx_hash = 0, and the pending result is lost. After deassertion, the first accepted block computes correctly.

## Configuration
- SHA256_FEEDFORWARD_EN defined:
  - FINAL writes saved-IV + working state, which is the full FIPS 180-4 compression output.
- SHA256_FEEDFORWARD_EN undefined:
  - FINAL writes the raw working state a..h after round 63.
  - The saved-IV register and its adders are omitted.
  - This mode is used when a downstream block performs the addition itself or compares only state words.

## Test plan
All directed cases use the standard IV 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.

- **"abc" block**
  - Stimulus: W0 = 61626380, W1..W14 = 0, W15 = 00000018.
  - Required response with SHA256_FEEDFORWARD_EN: tx_hash words 0..7 = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
  - Required timing: out_valid exactly N+1 clocks after accept.
- **Empty message, all ROUNDS_PER_CYCLE values**
  - Stimulus: W0 = 80000000, all other words 0; run with ROUNDS_PER_CYCLE = 1, 2, 4, 8.
  - Required response: e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
  - Required timing: latency 65 / 33 / 17 / 9 respectively.
- **Feed-forward disabled**
  - Stimulus: the "abc" block with SHA256_FEEDFORWARD_EN undefined.
  - Required response: tx_hash equals the expected "abc" digest minus the IV, word-wise mod 2^32.
- **Backpressure**
  - Stimulus: hold out_ready low for 10 cycles after out_valid.
  - Required response: tx_hash and out_valid stay stable and in_ready stays 0.
  - Then stimulus: raise out_ready together with in_valid.
  - Required response: the next block is accepted in that same cycle and busy rises on the next edge.
- **Ignored input while busy**
  - Stimulus: toggle in_valid and rx_input throughout RUN.
  - Required response: in_ready = 0 and the result is unaffected.
- **Reset mid-operation**
  - Stimulus: assert reset asynchronously (between edges) at rc = 32.
  - Required response: out_valid, tx_hash and busy are 0 immediately.
  - Then stimulus: deassert reset and issue "abc".
  - Required response: the correct digest.
